instruction_fetch: RTL

Instruction-fetch stage of the MIPS pipeline. It owns the program counter, issues word requests to instruction memory over a req/ack handshake, and registers the returned word into the IF/ID pipeline register. That register drives the downstream decode/splitter stage's `instruction` input. It handles stall, flush and branch redirects, including redirects that arrive while a memory request is still outstanding.

---
 rtl/mips_pkg.sv | 12 +
 rtl/if_id_reg.sv | 31 +++
 rtl/instruction_fetch.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, the NOP encoding and the fetch FSM states.
package mips_pkg;
    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        DISCARD
    } if_state_t;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register; a bubble clears valid and forces the NOP encoding, winning over load.
module if_id_reg
    import mips_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              bubble,
    input  logic [WORD_W-1:0] instr_d,
    input  logic [WORD_W-1:0] pc_plus4_d,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instruction <= NOP;
            pc_plus4    <= '0;
            valid       <= 1'b0;
        end else if (bubble) begin
            instruction <= NOP;
            valid       <= 1'b0;
        end else if (load) begin
            instruction <= instr_d;
            pc_plus4    <= pc_plus4_d;
            valid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// MIPS fetch stage: PC, req/ack imem handshake, skid buffer and redirect handling.
// Optional IFETCH_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [WORD_W-1:0] branch_target,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              valid
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [WORD_W-1:0] fetch_count,
    output logic [WORD_W-1:0] stall_count
`endif
);

    if_state_t         state, next_state;
    logic [WORD_W-1:0] pc, next_pc, req_addr, req_plus4, skid, ifid_data;
    logic              new_req, ifid_load, ifid_bubble, skid_load;

    assign req_plus4 = req_addr + 32'd4;
    assign imem_req  = (state == FETCH) || (state == DISCARD);
    assign imem_addr = req_addr;

    always_comb begin
        next_state  = state;
        next_pc     = pc;
        new_req     = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_data   = imem_rdata;
        skid_load   = 1'b0;

        case (state)
            IDLE: begin
                next_state = FETCH;
                new_req    = 1'b1;
            end
            FETCH: begin
                if (imem_ack) begin
                    if (stall) begin
                        next_state = HOLD;
                        skid_load  = 1'b1;
                    end else begin
                        ifid_load = 1'b1;
                        next_pc   = req_plus4;
                        new_req   = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    ifid_load  = 1'b1;
                    ifid_data  = skid;
                    next_pc    = req_plus4;
                    next_state = FETCH;
                    new_req    = 1'b1;
                end
            end
            DISCARD: begin
                if (imem_ack) begin
                    next_state = FETCH;
                    new_req    = 1'b1;
                end
            end
        endcase

        // A redirect overrides everything above; an un-acked request must still complete.
        if (branch_taken) begin
            next_pc   = branch_target & ~32'h3;
            ifid_load = 1'b0;
            skid_load = 1'b0;
            if (state != IDLE) begin
                ifid_bubble = 1'b1;
                if (imem_req && !imem_ack) begin
                    next_state = DISCARD;
                    new_req    = 1'b0;
                end else begin
                    next_state = FETCH;
                    new_req    = 1'b1;
                end
            end
        end

        if (flush)
            ifid_bubble = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            skid     <= NOP;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            if (new_req)
                req_addr <= next_pc;
            if (skid_load)
                skid <= imem_rdata;
        end
    end

    if_id_reg u_if_id (
        .clk         (clk),
        .reset       (reset),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr_d     (ifid_data),
        .pc_plus4_d  (req_plus4),
        .instruction (instruction),
        .pc_plus4    (pc_plus4),
        .valid       (valid)
    );

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (ifid_load && !ifid_bubble)
                fetch_count <= fetch_count + 32'd1;
            if (stall && valid)
                stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule
